// File: rtl/ppu_vram_pkg.sv
// Shared types, address map constants and decode helpers for the PPU VRAM responder.
package ppu_vram_pkg;

    typedef enum logic [1:0] {
        MIR_HORZ = 2'd0,
        MIR_VERT = 2'd1,
        MIR_SS_A = 2'd2,
        MIR_SS_B = 2'd3
    } mirror_t;

    typedef enum logic [1:0] {
        REG_CHR = 2'd0,
        REG_NT  = 2'd1,
        REG_PAL = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } cpu_state_t;

    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] PAL_BASE = 14'h3F00;

    function automatic region_t decode_region(input logic [13:0] addr);
        if (addr < NT_BASE) begin
            return REG_CHR;
        end
        if (addr >= PAL_BASE) begin
            return REG_PAL;
        end
        return REG_NT;
    endfunction

    // Sprite entries 0x10/14/18/1C share storage with background entries 0x00/04/08/0C.
    function automatic logic [4:0] pal_fold(input logic [4:0] idx);
        if (idx[4] && (idx[1:0] == 2'b00)) begin
            return {1'b0, idx[3:0]};
        end
        return idx;
    endfunction

endpackage

// File: rtl/ppu_vram_responder_if.sv
// CPU-side ($2007) request/ack port of the PPU VRAM responder; master = CPU, slave = responder.
interface ppu_vram_responder_if;
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ppu_palette_ram.sv
// 32-entry palette register file with mirror folding; read data registered, writes land at the clock edge.
module ppu_palette_ram
    import ppu_vram_pkg::*;
#(
    parameter int PAL_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [4:0]           idx,
    input  logic [PAL_WIDTH-1:0] wdata,
    output logic [PAL_WIDTH-1:0] rdata
);

    logic [PAL_WIDTH-1:0] mem [32];
    logic [4:0]           fidx;

    assign fidx = pal_fold(idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            rdata <= mem[fidx];
            if (we) begin
                mem[fidx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/ppu_vram_responder.sv
// Decodes PPU VRAM reads to CHR / mirrored CIRAM / palette; ppu_rdata follows ppu_addr by one cycle.
// CPU port waits while rendering_active, then GRANT+RESP (ack >= 2 cycles); PPU_CHR_RAM_EN adds CHR writes.
module ppu_vram_responder
    import ppu_vram_pkg::*;
#(
    parameter int NT_DEPTH  = 2048,
    parameter int PAL_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [13:0]          ppu_addr,
    output logic [7:0]           ppu_rdata,
    input  logic                 rendering_active,
    input  logic [1:0]           mirror_mode,
    ppu_vram_responder_if.slave  cpu,
    output logic [12:0]          chr_addr,
`ifdef PPU_CHR_RAM_EN
    output logic                 chr_we,
    output logic [7:0]           chr_wdata,
`endif
    input  logic [7:0]           chr_rdata
);

    localparam int NT_AW = $clog2(NT_DEPTH);

    cpu_state_t           state, state_nxt;
    logic [13:0]          sel_addr;
    region_t              region, region_q;
    mirror_t              mirror;
    logic                 page;
    logic [NT_AW-1:0]     nt_idx;
    logic                 wr_en;
    logic                 rd_vld_q;
    logic [7:0]           ciram [NT_DEPTH];
    logic [7:0]           nt_q;
    logic [7:0]           rd_data;
    logic [PAL_WIDTH-1:0] pal_q;

    assign sel_addr = (state == GRANT) ? cpu.addr : ppu_addr;
    assign region   = decode_region(sel_addr);
    assign mirror   = mirror_t'(mirror_mode);
    assign chr_addr = rst_n ? sel_addr[12:0] : 13'd0;

    always_comb begin
        page = 1'b0;
        case (mirror)
            MIR_HORZ: page = sel_addr[11];
            MIR_VERT: page = sel_addr[10];
            MIR_SS_A: page = 1'b0;
            default:  page = 1'b1;
        endcase
    end

    // 0x3000-0x3EFF aliases 0x2000 naturally: bits [13:12] never reach the index.
    assign nt_idx = NT_AW'({page, sel_addr[9:0]});

    always_ff @(posedge clk) begin
        if (wr_en && (region == REG_NT)) begin
            ciram[nt_idx] <= cpu.wdata;
        end
        nt_q <= ciram[nt_idx];
    end

    ppu_palette_ram #(
        .PAL_WIDTH (PAL_WIDTH)
    ) u_palette (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && (region == REG_PAL)),
        .idx   (sel_addr[4:0]),
        .wdata (cpu.wdata[PAL_WIDTH-1:0]),
        .rdata (pal_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q <= REG_CHR;
            rd_vld_q <= 1'b0;
            state    <= IDLE;
        end else begin
            region_q <= region;
            rd_vld_q <= 1'b1;
            state    <= state_nxt;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (region_q)
            REG_CHR: rd_data = chr_rdata;
            REG_NT:  rd_data = nt_q;
            REG_PAL: rd_data = 8'(pal_q);
            default: rd_data = 8'h00;
        endcase
    end

    assign ppu_rdata = rd_vld_q ? rd_data : 8'h00;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        cpu.ack   = 1'b0;
        cpu.rdata = 8'h00;
        case (state)
            IDLE: begin
                if (cpu.req && !rendering_active) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                wr_en     = cpu.we;
                state_nxt = RESP;
            end
            RESP: begin
                cpu.ack   = 1'b1;
                cpu.rdata = rd_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PPU_CHR_RAM_EN
    assign chr_we    = wr_en && (region == REG_CHR);
    assign chr_wdata = cpu.wdata;
`endif

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed bench for ppu_vram_responder: mirroring, palette aliasing, CHR latency, CPU stall and reset abort.
module tb_ppu_vram_responder;

    logic        clk;
    logic        rst_n;
    logic [13:0] ppu_addr;
    logic [7:0]  ppu_rdata;
    logic        rendering_active;
    logic [1:0]  mirror_mode;
    logic [12:0] chr_addr;
    logic [7:0]  chr_rdata;
`ifdef PPU_CHR_RAM_EN
    logic        chr_we;
    logic [7:0]  chr_wdata;
`endif

    int checks = 0;
    int errors = 0;

    ppu_vram_responder_if cpu_bus ();

    ppu_vram_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ppu_addr         (ppu_addr),
        .ppu_rdata        (ppu_rdata),
        .rendering_active (rendering_active),
        .mirror_mode      (mirror_mode),
        .cpu              (cpu_bus),
        .chr_addr         (chr_addr),
`ifdef PPU_CHR_RAM_EN
        .chr_we           (chr_we),
        .chr_wdata        (chr_wdata),
`endif
        .chr_rdata        (chr_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External CHR ROM model: synchronous, one cycle of read latency.
    function automatic logic [7:0] chr_fn(input logic [12:0] a);
        if (a == 13'h0123) begin
            return 8'h7E;
        end
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        chr_rdata <= chr_fn(chr_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a rising edge; leaves one idle cycle after the ack.
    task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int lat);
        logic acked;
        acked         = 1'b0;
        rd            = 8'h00;
        lat           = 0;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = we;
        cpu_bus.addr  = a;
        cpu_bus.wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_bus.ack) begin
                acked = 1'b1;
                rd    = cpu_bus.rdata;
                break;
            end
        end
        cpu_bus.req = 1'b0;
        if (!acked) begin
            check("ack_timeout", 32'(acked), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ppu_read(input logic [13:0] a, output logic [7:0] rd);
        ppu_addr = a;
        @(posedge clk);
        #1;
        rd = ppu_rdata;
    endtask

    logic [7:0] rd;
    int         lat;
    int         acks;

    initial begin
        rst_n            = 1'b0;
        ppu_addr         = 14'h0ABC;
        rendering_active = 1'b0;
        mirror_mode      = 2'd1;
        cpu_bus.req      = 1'b0;
        cpu_bus.we       = 1'b0;
        cpu_bus.addr     = 14'h0000;
        cpu_bus.wdata    = 8'h00;

        #12;
        check("rst_ppu_rdata", 32'(ppu_rdata), 32'h00);
        check("rst_cpu_ack", 32'(cpu_bus.ack), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_bus.rdata), 32'h00);
        check("rst_chr_addr", 32'(chr_addr), 32'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        ppu_read(14'h3F00, rd);
        check("pal_rst_3f00", 32'(rd), 32'h00);
        ppu_read(14'h3F1F, rd);
        check("pal_rst_3f1f", 32'(rd), 32'h00);

        // Vertical mirroring: 0x2000/0x2800 share page 0, 0x2400/0x2C00 share page 1.
        mirror_mode = 2'd1;
        cpu_access(1'b1, 14'h2000, 8'h11, rd, lat);
        check("cpu_wr_latency", 32'(lat), 32'd2);
        cpu_access(1'b1, 14'h2400, 8'h55, rd, lat);
        ppu_read(14'h2C00, rd);
        check("vert_2c00", 32'(rd), 32'h55);
        ppu_read(14'h2000, rd);
        check("vert_2000", 32'(rd), 32'h11);
        ppu_read(14'h2800, rd);
        check("vert_2800", 32'(rd), 32'h11);
        cpu_access(1'b0, 14'h2C00, 8'h00, rd, lat);
        check("vert_cpu_rd_2c00", 32'(rd), 32'h55);
        check("cpu_rd_latency", 32'(lat), 32'd2);

        // Horizontal mirroring: 0x2000/0x2400 page 0, 0x2800/0x2C00 page 1.
        mirror_mode = 2'd0;
        cpu_access(1'b1, 14'h2800, 8'h22, rd, lat);
        cpu_access(1'b1, 14'h2000, 8'hA1, rd, lat);
        ppu_read(14'h2400, rd);
        check("horz_2400", 32'(rd), 32'hA1);
        ppu_read(14'h2800, rd);
        check("horz_2800", 32'(rd), 32'h22);
        ppu_read(14'h3000, rd);
        check("horz_3000_alias", 32'(rd), 32'hA1);

        mirror_mode = 2'd3;
        ppu_read(14'h2000, rd);
        check("ss_b_2000", 32'(rd), 32'h22);
        mirror_mode = 2'd2;
        ppu_read(14'h2C00, rd);
        check("ss_a_2c00", 32'(rd), 32'hA1);
        mirror_mode = 2'd0;

        // Palette aliasing and 6-bit storage.
        cpu_access(1'b1, 14'h3F10, 8'h2A, rd, lat);
        cpu_access(1'b1, 14'h3F01, 8'hFF, rd, lat);
        ppu_read(14'h3F00, rd);
        check("pal_3f00", 32'(rd), 32'h2A);
        ppu_read(14'h3F01, rd);
        check("pal_3f01", 32'(rd), 32'h3F);
        ppu_read(14'h3F11, rd);
        check("pal_3f11", 32'(rd), 32'h00);
        ppu_read(14'h3F10, rd);
        check("pal_3f10", 32'(rd), 32'h2A);
        cpu_access(1'b0, 14'h3F01, 8'h00, rd, lat);
        check("pal_cpu_rd_3f01", 32'(rd), 32'h3F);

        // CHR: address combinational, data one cycle later.
        ppu_addr = 14'h0123;
        #1;
        check("chr_addr_comb", 32'(chr_addr), 32'h0123);
        @(posedge clk);
        #1;
        check("chr_rdata_n1", 32'(ppu_rdata), 32'h7E);
        ppu_read(14'h0456, rd);
        check("chr_0456", 32'(rd), 32'(8'h56 ^ 8'hA5));

        cpu_access(1'b1, 14'h0123, 8'h00, rd, lat);
        check("chr_wr_acked", 32'(lat), 32'd2);
        ppu_read(14'h0123, rd);
        check("chr_after_wr", 32'(rd), 32'h7E);

        // CPU stalled by rendering, then granted once rendering stops.
        rendering_active = 1'b1;
        cpu_bus.req      = 1'b1;
        cpu_bus.we       = 1'b0;
        cpu_bus.addr     = 14'h2000;
        acks             = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (cpu_bus.ack) acks++;
        end
        check("stall_no_ack", 32'(acks), 32'd0);
        rendering_active = 1'b0;
        @(posedge clk);
        #1;
        check("stall_release_t1", 32'(cpu_bus.ack), 32'h0);
        @(posedge clk);
        #1;
        check("stall_release_t2", 32'(cpu_bus.ack), 32'h1);
        check("stall_rdata", 32'(cpu_bus.rdata), 32'hA1);
        cpu_bus.req = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted while the FSM is in GRANT.
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b1;
        cpu_bus.addr  = 14'h3F05;
        cpu_bus.wdata = 8'h12;
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        cpu_bus.req = 1'b0;
        acks        = 0;
        #1;
        if (cpu_bus.ack) acks++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (cpu_bus.ack) acks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (cpu_bus.ack) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'd0);
        ppu_read(14'h3F00, rd);
        check("rst_mid_pal_3f00", 32'(rd), 32'h00);
        ppu_read(14'h3F05, rd);
        check("rst_mid_pal_3f05", 32'(rd), 32'h00);
        cpu_access(1'b0, 14'h3F01, 8'h00, rd, lat);
        check("rst_mid_idle_lat", 32'(lat), 32'd2);
        check("rst_mid_pal_3f01", 32'(rd), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_vram_responder.md
Name: ppu_vram_responder

Overview:
- Responder end of the PPU VRAM read interface. Decodes the 14-bit PPU address issued by the background and sprite renderers and returns the data byte.
- Routes each access to one of three targets: external CHR memory, the internal 2 KB nametable RAM (CIRAM) with cartridge mirroring, or the internal 32-entry palette RAM.
- Also serves a CPU-side access port ($2007 path) through a request/ack handshake. This port is arbitrated against rendering.

Parameters:
- NT_DEPTH, 2048, CIRAM size in bytes (address width = $clog2(NT_DEPTH)).
- PAL_WIDTH, 6, stored bits per palette entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ppu_addr  in  14  renderer read address, sampled every cycle
- ppu_rdata  out  8  renderer read data, valid 1 cycle after address
- rendering_active  in  1  renderer owns memory this cycle
- mirror_mode  in  2  0=horizontal, 1=vertical, 2=single-screen A, 3=single-screen B
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  14  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data, valid while cpu_ack=1
- chr_addr  out  13  external CHR memory address (synchronous memory, 1-cycle read latency)
- chr_rdata  in  8  external CHR read data

Behaviour:
- Reset values:
  - ppu_rdata=0, cpu_ack=0, cpu_rdata=0, chr_addr=0.
  - FSM=IDLE.
  - All palette entries=0. CIRAM contents are undefined.
- Address select:
  - sel_addr = cpu_addr when FSM=GRANT, else ppu_addr.
  - All memories see sel_addr in the same cycle.
- Address decode on sel_addr[13:0]:
  - 0x0000-0x1FFF: CHR. chr_addr = sel_addr[12:0], driven combinationally.
  - 0x2000-0x3EFF: nametable. Bits [11:10] select the logical table; 0x3000-0x3EFF aliases 0x2000-0x2EFF.
    - CIRAM index = {page, sel_addr[9:0]}.
    - page = addr[11] for horizontal, addr[10] for vertical, 0 for single-screen A, 1 for single-screen B.
  - 0x3F00-0x3FFF: palette. idx = addr[4:0]. If addr[4]=1 and addr[1:0]=0, clear idx[4] (0x3F10/14/18/1C alias 0x3F00/04/08/0C).
- Read latency:
  - Region select is registered alongside the memory reads.
  - ppu_rdata(n+1) = data at ppu_addr(n) for every region.
  - Palette reads return {2'b00, entry[5:0]}.
- Palette writes store wdata[5:0].
- CPU FSM:
  - IDLE: if cpu_req && !rendering_active, go to GRANT. Otherwise stay.
  - GRANT (1 cycle): the CPU address drives the memories and the write strobe is asserted if cpu_we. Go to RESP.
  - RESP (1 cycle): cpu_ack=1. cpu_rdata = registered read data (old contents for reads, don't-care for writes). Go to IDLE.
  - Minimum latency from request to ack is 2 cycles.
  - The requester drops cpu_req in the cycle after cpu_ack. The FSM re-samples it in IDLE.
- Boundary conditions:
  - rendering_active rising during GRANT or RESP: the access completes anyway; the renderer data for that cycle is corrupted. This is accepted behaviour, matching the hardware.
  - rendering_active held high: the CPU stalls indefinitely with no ack.
  - CPU writes to CHR with the feature off: dropped, still acked.
  - Reset mid-access: FSM returns to IDLE. No ack. A partially issued write may or may not land.
  - cpu_addr is 14 bits, so the 0x4000 wrap is handled by the caller.

Optional Feature:
- PPU_CHR_RAM_EN.
- Defined: adds outputs chr_we (1) and chr_wdata (8). CPU writes to 0x0000-0x1FFF assert chr_we for the GRANT cycle with chr_wdata = cpu_wdata.
- Undefined: no such ports; CHR is read-only and CHR writes are discarded.

Decomposition:
- Package ppu_vram_pkg:
  - mirror_t enum (MIR_HORZ, MIR_VERT, MIR_SS_A, MIR_SS_B).
  - region_t enum (REG_CHR, REG_NT, REG_PAL).
  - Constants NT_BASE=14'h2000 and PAL_BASE=14'h3F00.
  - cpu_state_t enum (IDLE, GRANT, RESP).
- One sub-module: ppu_palette_ram (32x6 register file with alias folding, registered read, async reset clear).

Test Plan:
- Vertical mirroring, CPU writes 0x2400=0x55 -> ppu_addr 0x2C00 returns 0x55 one cycle later; 0x2000 and 0x2800 do not read 0x55.
- Horizontal mirroring, CPU writes 0x2000=0xA1 -> 0x2400 reads 0xA1; 0x2800 does not read 0xA1; 0x3000 reads 0xA1.
- CPU writes 0x3F10=0x2A, then 0x3F01=0xFF -> 0x3F00 reads 0x2A; 0x3F01 reads 0x3F; 0x3F11 does not alias 0x3F01.
- ppu_addr=0x0123 at cycle n with CHR model returning 0x7E -> chr_addr=0x0123 at n; ppu_rdata=0x7E at n+1.
- cpu_req with rendering_active=1 for 10 cycles -> cpu_ack stays 0; rendering_active falls at cycle t -> cpu_ack=1 at t+2.
- rst_n asserted during GRANT -> cpu_ack never pulses; after release, FSM is IDLE and the palette reads 0.
